// File: rtl/kdtree_wbs_pkg.sv
// kdtree_wbs_pkg: shared address map, register offsets and enums for the KD-tree Wishbone slave.
package kdtree_wbs_pkg;

    localparam logic [31:0] WBS_ADDR_MASK = 32'hFFFF_0000;
    localparam logic [31:0] BASE_REG      = 32'h3000_0000;
    localparam logic [31:0] BASE_QUERY    = 32'h3001_0000;
    localparam logic [31:0] BASE_LEAF     = 32'h3002_0000;
    localparam logic [31:0] BASE_BEST     = 32'h3003_0000;
    localparam logic [31:0] BASE_NODE     = 32'h3004_0000;

    localparam logic [15:0] OFF_MODE  = 16'h0000;
    localparam logic [15:0] OFF_DEBUG = 16'h0004;
    localparam logic [15:0] OFF_DONE  = 16'h0008;
    localparam logic [15:0] OFF_START = 16'h000C;
    localparam logic [15:0] OFF_BUSY  = 16'h0010;

    typedef enum logic [2:0] {REG, QUERY, LEAF, BEST, NODE, NONE} region_t;
    typedef enum logic [2:0] {IDLE, FULLW, RDW, ACK, TURN} state_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wbs_region_decode.sv
// wbs_region_decode: maps a Wishbone byte address to its target region and register offset.
module wbs_region_decode
    import kdtree_wbs_pkg::*;
(
    input  logic [31:0] adr,
    output region_t     region,
    output logic [15:0] off
);

    logic [31:0] page;

    assign page = adr & WBS_ADDR_MASK;
    assign off  = adr[15:0];

    always_comb
        region = page == BASE_REG   ? REG   :
                 page == BASE_QUERY ? QUERY :
                 page == BASE_LEAF  ? LEAF  :
                 page == BASE_BEST  ? BEST  :
                 page == BASE_NODE  ? NODE  : NONE;

endmodule

// File: rtl/wbs_kdtree_slave.sv
// wbs_kdtree_slave: Wishbone classic responder fanning host cycles out to KD-tree registers, FIFOs and arrays.
// Define WBS_TIMEOUT_EN to abandon FIFO-full waits after STALL_LIMIT cycles and flag it in DEBUG[31].
module wbs_kdtree_slave
    import kdtree_wbs_pkg::*;
#(
    parameter int DATA_WIDTH  = 11,
    parameter int NUM_LEAVES  = 64,
    parameter int ADDR_WIDTH  = $clog2(NUM_LEAVES),
    parameter int STALL_LIMIT = 256
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic                    mode_o,
    output logic                    fsm_start_o,
    input  logic                    fsm_busy_i,
    input  logic                    fsm_done_i,
    output logic                    node_we_o,
    output logic [ADDR_WIDTH-1:0]   node_addr_o,
    output logic [2*DATA_WIDTH-1:0] node_wdata_o,
    output logic                    leaf_wenq_o,
    output logic [DATA_WIDTH-1:0]   leaf_wdata_o,
    input  logic                    leaf_wfull_n_i,
    output logic                    query_wenq_o,
    output logic [DATA_WIDTH-1:0]   query_wdata_o,
    input  logic                    query_wfull_n_i,
    output logic                    best_rd_o,
    output logic [ADDR_WIDTH+2:0]   best_addr_o,
    input  logic [DATA_WIDTH-1:0]   best_rdata_i
);

    region_t               region;
    logic [15:0]           off;
    state_t                state;
    logic [31:0]           debug, debug_n, rdata, lane;
    logic [ADDR_WIDTH+2:0] best_addr_q;
    logic                  req, word, fifo, full_n, enter_ack, timeout, reg_wr, node_wr, push;

    wbs_region_decode u_decode (
        .adr    (wbs_adr_i),
        .region (region),
        .off    (off)
    );

    assign req    = wbs_cyc_i & wbs_stb_i;
    assign word   = wbs_sel_i == 4'hF;
    assign fifo   = region == LEAF || region == QUERY;
    assign full_n = region == LEAF ? leaf_wfull_n_i : query_wfull_n_i;
    assign lane   = byte_mask(wbs_sel_i);

`ifdef WBS_TIMEOUT_EN
    localparam int CW = $clog2(STALL_LIMIT + 1);
    logic [CW-1:0] stall_cnt;

    assign timeout = req && state == FULLW && !full_n && stall_cnt == CW'(STALL_LIMIT - 1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state != FULLW)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // Every path into ACK funnels through enter_ack so the side-effect strobes land in the ACK cycle.
    assign enter_ack = req && (state == IDLE  ? (fifo ? full_n : region != BEST) :
                               state == FULLW ? (full_n || timeout) :
                               state == RDW);
    assign reg_wr    = enter_ack && wbs_we_i && region == REG;
    assign node_wr   = enter_ack && wbs_we_i && region == NODE && word;
    assign push      = enter_ack && wbs_we_i && fifo && full_n && word;

    // The array returns data one cycle after the strobe, so address and strobe go out in the request cycle.
    assign best_rd_o   = !wb_rst_i && state == IDLE && req && region == BEST;
    assign best_addr_o = best_rd_o ? wbs_adr_i[ADDR_WIDTH+2:0] : best_addr_q;

    always_comb begin
        rdata = '0;
        if (region == BEST)
            rdata[DATA_WIDTH-1:0] = best_rdata_i;
        else if (region == REG)
            rdata = off == OFF_MODE  ? {31'b0, mode_o}     :
                    off == OFF_DEBUG ? debug               :
                    off == OFF_DONE  ? {31'b0, fsm_done_i} :
                    off == OFF_BUSY  ? {31'b0, fsm_busy_i} : '0;
    end

    always_comb begin
        debug_n = reg_wr && off == OFF_DEBUG ? (debug & ~lane) | (wbs_dat_i & lane) : debug;
`ifdef WBS_TIMEOUT_EN
        debug_n[31] = timeout || (debug[31] && !(reg_wr && off == OFF_DEBUG && wbs_sel_i[3] && !wbs_dat_i[31]));
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            mode_o        <= 1'b0;
            fsm_start_o   <= 1'b0;
            node_we_o     <= 1'b0;
            node_addr_o   <= '0;
            node_wdata_o  <= '0;
            leaf_wenq_o   <= 1'b0;
            leaf_wdata_o  <= '0;
            query_wenq_o  <= 1'b0;
            query_wdata_o <= '0;
            debug         <= '0;
            best_addr_q   <= '0;
        end else begin
            wbs_ack_o    <= enter_ack;
            wbs_dat_o    <= enter_ack && !wbs_we_i ? rdata : '0;
            fsm_start_o  <= reg_wr && off == OFF_START && wbs_dat_i[0] && !fsm_busy_i;
            node_we_o    <= node_wr;
            leaf_wenq_o  <= push && region == LEAF;
            query_wenq_o <= push && region == QUERY;
            debug        <= debug_n;
            if (reg_wr && off == OFF_MODE)
                mode_o <= wbs_dat_i[0];
            if (node_wr) begin
                node_addr_o  <= wbs_adr_i[ADDR_WIDTH-1:0];
                node_wdata_o <= wbs_dat_i[2*DATA_WIDTH-1:0];
            end
            if (push && region == LEAF)
                leaf_wdata_o <= wbs_dat_i[DATA_WIDTH-1:0];
            if (push && region == QUERY)
                query_wdata_o <= wbs_dat_i[DATA_WIDTH-1:0];
            if (best_rd_o)
                best_addr_q <= wbs_adr_i[ADDR_WIDTH+2:0];
            case (state)
                IDLE:       state <= !req ? IDLE : enter_ack ? ACK : region == BEST ? RDW : FULLW;
                FULLW, RDW: state <= !req ? IDLE : enter_ack ? ACK : state;
                ACK:        state <= TURN;
                default:    state <= IDLE;
            endcase
        end
    end

endmodule
